lap_recorder: RTL and testbench
===============================

LAP_RECORDER -- requirements
Module: lap_recorder

Interface
REQ-001 Parameter DEPTH, default 4, lap FIFO entries; power of two, at least 2.
REQ-002 Parameter TW, default 16, time value width in counter units.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous user clear, active-high.
REQ-006 enable  input  1  stopwatch running indication from the control FSM.
REQ-007 lap_req  input  1  lap button level, already debounced and synchronous to clk.
REQ-008 time_in  input  TW  current stopwatch time.
REQ-009 lap_ready  input  1  consumer accepts the head entry.
REQ-010 lap_valid  output  1  FIFO non-empty; head entry presented.
REQ-011 lap_time  output  TW  head entry captured time.
REQ-012 lap_delta  output  TW  head entry time since the previous capture.
REQ-013 lap_count  output  log2(DEPTH)+1  entries currently stored.
REQ-014 lap_index  output  8  total laps accepted since reset or clear, saturating.
REQ-015 overflow  output  1  sticky flag: a lap was dropped because the FIFO was full.

Function
REQ-016 The block SHALL register lap_req each cycle and detect a lap event as lap_req=1 with the previous sample=0 (one event per press).
REQ-017 A lap event SHALL be accepted only when enable=1 in the same cycle; events with enable=0 are discarded with no state change.
REQ-018 On an accepted event with the FIFO not full, the block SHALL write {time_in, time_in - last_time} (delta modulo 2^TW) at the tail, set last_time to time_in, and increment lap_index, saturating at 255.
REQ-019 On an accepted event with the FIFO full and no pop in the same cycle, the block SHALL drop the entry, set overflow=1, and leave last_time and lap_index unchanged.
REQ-020 A pop SHALL occur when lap_valid=1 and lap_ready=1; the head advances on that clock edge.
REQ-021 Push and pop in the same cycle with the FIFO full SHALL both occur; the count is unchanged and overflow is not set.
REQ-022 Push into an empty FIFO SHALL assert lap_valid on the following cycle; the FIFO SHALL NOT bypass an entry in the cycle it is written.
REQ-023 lap_time and lap_delta SHALL hold the head entry stably while lap_valid=1 and lap_ready=0.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; lap_count = writes - reads, in the range 0..DEPTH.
REQ-025 clear=1 SHALL empty the FIFO and zero lap_index, overflow, and last_time on the next edge, taking priority over a simultaneous push or pop; the lap_req edge register still updates.
REQ-026 lap_time and lap_delta are don't-care when lap_valid=0 but SHALL NOT be X after reset.
REQ-027 A change of enable SHALL NOT alter stored entries or last_time.

Reset
REQ-028 While rst=1, asynchronously: lap_valid=0, lap_count=0, lap_index=0, overflow=0, pointers=0, last_time=0, lap_req edge register=0, storage=0.
REQ-029 After rst deasserts, the first lap event is evaluated no earlier than the first rising edge.
REQ-030 Reset mid-press: if lap_req is held at 1 through deassertion of rst, the block SHALL record one lap event on the first edge after reset, provided enable=1.

Verification
REQ-031 enable=1, laps at time_in=100, 250, 400, lap_ready=0 -> lap_count=3, lap_index=3; then pop -> entries in order (100,100), (250,150), (400,150).
REQ-032 enable=0, lap press at time_in=500 -> no entry, lap_index unchanged; enable=1 with lap_req held high -> no event until release and re-press.
REQ-033 DEPTH=4, 5 laps with no pops -> lap_count=4, overflow=1, lap_index=4; the fifth entry is absent; overflow stays 1 after draining, until clear.
REQ-034 FIFO full, lap event and pop in the same cycle -> lap_count stays 4, overflow=0, and the newest entry is at the tail.
REQ-035 last_time=0xFFF0, lap at time_in=0x0010 -> lap_delta=0x0020 (wrap).
REQ-036 Entries stored and a lap event in the same cycle as clear=1 -> next cycle lap_count=0, lap_valid=0, lap_index=0, overflow=0; an async rst pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/lap_recorder.sv
// lap_recorder: captures stopwatch lap times and deltas into a small FIFO.
// An enabled rising edge on lap_req pushes one entry; overflow is sticky until clear.
module lap_recorder #(
   parameter int DEPTH = 4,
   parameter int TW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     enable,
   input  logic                     lap_req,
   input  logic [TW-1:0]            time_in,
   input  logic                     lap_ready,
   output logic                     lap_valid,
   output logic [TW-1:0]            lap_time,
   output logic [TW-1:0]            lap_delta,
   output logic [$clog2(DEPTH):0]   lap_count,
   output logic [7:0]               lap_index,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] last_time;
   logic [TW-1:0] mem_t [DEPTH];
   logic [TW-1:0] mem_d [DEPTH];
   logic          req_q, accept, full, push, pop, drop;
   always_comb begin
      accept = lap_req & ~req_q & enable;
      full   = count == CW'(DEPTH);
      pop    = lap_valid & lap_ready;
      push   = accept & (~full | pop);
      drop   = accept & full & ~pop;
   end
   assign lap_valid = count != '0;
   assign lap_count = count;
   assign lap_time  = mem_t[rd_ptr];
   assign lap_delta = mem_d[rd_ptr];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_time <= '0;
         lap_index <= '0;
         overflow  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_t[i] <= '0;
            mem_d[i] <= '0;
         end
      end else begin
         req_q <= lap_req;
         if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_time <= '0;
            lap_index <= '0;
            overflow  <= 1'b0;
         end else begin
            if (push) begin
               mem_t[wr_ptr] <= time_in;
               mem_d[wr_ptr] <= time_in - last_time;
               wr_ptr        <= wr_ptr + 1'b1;
               last_time     <= time_in;
               if (lap_index != 8'hFF) lap_index <= lap_index + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            if (drop) overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_lap_recorder.sv
// tb_lap_recorder: directed scenarios with hand-computed expectations for lap_recorder.
module tb_lap_recorder;
   logic        clk = 1'b0;
   logic        rst, clear, enable, lap_req, lap_ready;
   logic [15:0] time_in;
   logic        lap_valid, overflow;
   logic [15:0] lap_time, lap_delta;
   logic [2:0]  lap_count;
   logic [7:0]  lap_index;
   int          checks = 0;
   int          errors = 0;

   lap_recorder #(.DEPTH(4), .TW(16)) dut (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable), .lap_req(lap_req),
      .time_in(time_in), .lap_ready(lap_ready), .lap_valid(lap_valid),
      .lap_time(lap_time), .lap_delta(lap_delta), .lap_count(lap_count),
      .lap_index(lap_index), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [15:0] t);
      time_in = t;
      lap_req = 1'b1;
      step();
      lap_req = 1'b0;
      step();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; enable = 1'b1; lap_req = 1'b1; lap_ready = 1'b0; time_in = 16'd7;
      #12;
      checks++; if (lap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", lap_valid); end
      checks++; if (lap_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", lap_count); end
      checks++; if (lap_index !== 8'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", lap_index); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", overflow); end
      checks++; if (lap_time !== 16'd0 || lap_delta !== 16'd0) begin errors++; $display("FAIL reset_data got %0h/%0h exp 0/0", lap_time, lap_delta); end
      rst = 1'b0;
      step();
      checks++; if (lap_count !== 3'd1 || lap_index !== 8'd1) begin errors++; $display("FAIL midpress_count got %0d/%0d exp 1/1", lap_count, lap_index); end
      checks++; if (lap_time !== 16'd7 || lap_delta !== 16'd7) begin errors++; $display("FAIL midpress_entry got %0d/%0d exp 7/7", lap_time, lap_delta); end
      lap_req = 1'b0;
      do_clear();
      checks++; if (lap_count !== 3'd0 || lap_index !== 8'd0) begin errors++; $display("FAIL clear1 got %0d/%0d exp 0/0", lap_count, lap_index); end
   endtask

   task automatic test_basic();
      press(16'd100);
      checks++; if (lap_valid !== 1'b1 || lap_time !== 16'd100) begin errors++; $display("FAIL first_push got %0h/%0d exp 1/100", lap_valid, lap_time); end
      press(16'd250);
      press(16'd400);
      checks++; if (lap_count !== 3'd3 || lap_index !== 8'd3) begin errors++; $display("FAIL basic_count got %0d/%0d exp 3/3", lap_count, lap_index); end
      step();
      checks++; if (lap_time !== 16'd100 || lap_delta !== 16'd100) begin errors++; $display("FAIL hold_head got %0d/%0d exp 100/100", lap_time, lap_delta); end
      lap_ready = 1'b1;
      step();
      checks++; if (lap_time !== 16'd250 || lap_delta !== 16'd150) begin errors++; $display("FAIL pop2 got %0d/%0d exp 250/150", lap_time, lap_delta); end
      step();
      checks++; if (lap_time !== 16'd400 || lap_delta !== 16'd150) begin errors++; $display("FAIL pop3 got %0d/%0d exp 400/150", lap_time, lap_delta); end
      step();
      lap_ready = 1'b0;
      checks++; if (lap_valid !== 1'b0 || lap_count !== 3'd0) begin errors++; $display("FAIL drained got %0h/%0d exp 0/0", lap_valid, lap_count); end
   endtask

   task automatic test_enable();
      enable = 1'b0;
      press(16'd500);
      checks++; if (lap_count !== 3'd0 || lap_index !== 8'd3) begin errors++; $display("FAIL disabled got %0d/%0d exp 0/3", lap_count, lap_index); end
      lap_req = 1'b1;
      step();
      enable = 1'b1;
      step();
      step();
      checks++; if (lap_count !== 3'd0) begin errors++; $display("FAIL held_level got %0d exp 0", lap_count); end
      lap_req = 1'b0;
      step();
      press(16'd600);
      checks++; if (lap_count !== 3'd1 || lap_delta !== 16'd200 || lap_index !== 8'd4) begin errors++; $display("FAIL repress got %0d/%0d/%0d exp 1/200/4", lap_count, lap_delta, lap_index); end
      lap_ready = 1'b1;
      step();
      lap_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_clear();
      press(16'd10); press(16'd20); press(16'd30); press(16'd40); press(16'd50);
      checks++; if (lap_count !== 3'd4 || overflow !== 1'b1 || lap_index !== 8'd4) begin errors++; $display("FAIL ovf got %0d/%0h/%0d exp 4/1/4", lap_count, overflow, lap_index); end
      lap_ready = 1'b1;
      step(); step(); step();
      checks++; if (lap_time !== 16'd40 || lap_delta !== 16'd10) begin errors++; $display("FAIL ovf_tail got %0d/%0d exp 40/10", lap_time, lap_delta); end
      step();
      lap_ready = 1'b0;
      checks++; if (lap_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0h/%0h exp 0/1", lap_valid, overflow); end
      press(16'd60);
      checks++; if (lap_delta !== 16'd20 || lap_index !== 8'd5) begin errors++; $display("FAIL ovf_last got %0d/%0d exp 20/5", lap_delta, lap_index); end
      do_clear();
      checks++; if (overflow !== 1'b0 || lap_count !== 3'd0) begin errors++; $display("FAIL ovf_clear got %0h/%0d exp 0/0", overflow, lap_count); end
   endtask

   task automatic test_full_pop();
      press(16'd1); press(16'd2); press(16'd3); press(16'd4);
      time_in = 16'd5; lap_req = 1'b1; lap_ready = 1'b1;
      step();
      lap_req = 1'b0;
      checks++; if (lap_count !== 3'd4 || overflow !== 1'b0 || lap_time !== 16'd2) begin errors++; $display("FAIL fullpop got %0d/%0h/%0d exp 4/0/2", lap_count, overflow, lap_time); end
      step(); step();
      checks++; if (lap_time !== 16'd4) begin errors++; $display("FAIL fullpop_seq got %0d exp 4", lap_time); end
      step();
      checks++; if (lap_time !== 16'd5 || lap_delta !== 16'd1) begin errors++; $display("FAIL fullpop_tail got %0d/%0d exp 5/1", lap_time, lap_delta); end
      step();
      lap_ready = 1'b0;
      checks++; if (lap_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %0h exp 0", lap_valid); end
   endtask

   task automatic test_wrap();
      do_clear();
      press(16'hFFF0);
      checks++; if (lap_delta !== 16'hFFF0) begin errors++; $display("FAIL wrap_first got %0h exp fff0", lap_delta); end
      lap_ready = 1'b1;
      step();
      lap_ready = 1'b0;
      press(16'h0010);
      checks++; if (lap_time !== 16'h0010 || lap_delta !== 16'h0020) begin errors++; $display("FAIL wrap_delta got %0h/%0h exp 10/20", lap_time, lap_delta); end
      lap_ready = 1'b1;
      step();
      lap_ready = 1'b0;
   endtask

   task automatic test_clear_rst();
      press(16'd11); press(16'd22);
      time_in = 16'd33; lap_req = 1'b1; clear = 1'b1;
      step();
      clear = 1'b0; lap_req = 1'b0;
      checks++; if (lap_count !== 3'd0 || lap_valid !== 1'b0 || lap_index !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clear_push got %0d/%0h/%0d/%0h exp 0/0/0/0", lap_count, lap_valid, lap_index, overflow); end
      step();
      press(16'd44);
      checks++; if (lap_delta !== 16'd44 || lap_count !== 3'd1) begin errors++; $display("FAIL post_clear got %0d/%0d exp 44/1", lap_delta, lap_count); end
      rst = 1'b1;
      #1;
      checks++; if (lap_valid !== 1'b0 || lap_count !== 3'd0 || lap_index !== 8'd0 || lap_time !== 16'd0 || lap_delta !== 16'd0) begin errors++; $display("FAIL async_rst got %0h/%0d/%0d/%0d/%0d exp all 0", lap_valid, lap_count, lap_index, lap_time, lap_delta); end
      #1;
      rst = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_enable();
      test_overflow();
      test_full_pop();
      test_wrap();
      test_clear_rst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
